// File: rtl/flash_ctrl_pkg.sv
// Shared types, command codes and status-bit positions for the NOR flash controller.
// Also provides the byte-swap helper used on the read-data path.
package flash_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_RD,
    ST_PGM,
    ST_POLL
  } ctrl_state_t;

  typedef enum logic [2:0] {
    BC_IDLE,
    BC_S1,
    BC_S2,
    BC_S3,
    BC_RD
  } bc_state_t;

  localparam logic [15:0] FLASH_CMD_READ_ARRAY = 16'h00FF;
  localparam logic [15:0] FLASH_CMD_PROGRAM    = 16'h0040;

  localparam int STATUS_READY_BIT = 7;
  localparam int STATUS_ERR_HI    = 5;
  localparam int STATUS_ERR_LO    = 1;

  function automatic logic [15:0] swap_bytes(input logic [15:0] d, input bit en);
    return en ? {d[7:0], d[15:8]} : d;
  endfunction

endpackage

// File: rtl/flash_bus_cycle.sv
// Flash strobe sequencer: 3-cycle write cycle or (WAIT_CYCLES+1)-cycle read cycle per start.
// Owns the data-bus tristate; done marks the last cycle so the caller can chain cycles.
module flash_bus_cycle
  import flash_ctrl_pkg::*;
#(
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        rd,
  input  logic [15:0] wr_data,
  output logic        done,
  output logic        busy,
  output logic        ce,
  output logic        we,
  output logic        oe,
  inout  wire  [15:0] flash_data,
  output logic [15:0] rd_data
);

  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES);

  bc_state_t   state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic [15:0] dout_reg, dout_next;
  logic        drive;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= BC_IDLE;
      cnt_reg   <= '0;
      dout_reg  <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      dout_reg  <= dout_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    dout_next  = dout_reg;
    done       = 1'b0;
    unique case (state_reg)
      BC_S1: state_next = BC_S2;
      BC_S2: state_next = BC_S3;
      BC_S3: begin
        done       = 1'b1;
        state_next = BC_IDLE;
      end
      BC_RD: begin
        cnt_next = cnt_reg + 4'd1;
        if (cnt_reg == WAIT_LAST) begin
          done       = 1'b1;
          state_next = BC_IDLE;
        end
      end
      default: ;
    endcase
    // A new cycle may start from idle or directly on the last cycle of the previous one.
    if (start && (state_reg == BC_IDLE || done)) begin
      cnt_next = '0;
      if (rd) begin
        state_next = BC_RD;
      end else begin
        state_next = BC_S1;
        dout_next  = wr_data;
      end
    end
  end

  assign ce    = !(state_reg == BC_S1 || state_reg == BC_S2 || state_reg == BC_RD);
  assign we    = (state_reg != BC_S1);
  assign oe    = (state_reg != BC_RD);
  assign drive = (state_reg == BC_S1 || state_reg == BC_S2);
  assign busy  = (state_reg != BC_IDLE);

  assign flash_data = drive ? dout_reg : 16'hzzzz;
  assign rd_data    = flash_data;

endmodule

// File: rtl/flash_ctrl.sv
// NOR flash controller: req/ack port, read-array mode tracking, programmable read wait states.
// Optional word programming with status polling is compiled in with FLASH_WRITE_EN.
module flash_ctrl
  import flash_ctrl_pkg::*;
#(
  parameter int ADDR_W      = 23,
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = 2,
  parameter int SWAP_BYTES  = 0,
  parameter int POLL_LIMIT  = 4095
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ready,
  output logic              ack,
  output logic              err,
  output logic [DATA_W-1:0] rdata,
  inout  wire  [15:0]       flash_data,
  output logic [ADDR_W-1:0] flash_addr,
  output logic              flash_ce,
  output logic              flash_we,
  output logic              flash_oe,
  output logic              flash_rp,
  output logic              flash_byte,
  output logic              flash_vpen
);

  if (DATA_W != 16) begin : g_bad_data_w
    $error("flash_ctrl: DATA_W must be 16");
  end
  if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait
    $error("flash_ctrl: WAIT_CYCLES must be 1..15");
  end

`ifdef FLASH_WRITE_EN
  localparam bit WRITE_EN = 1'b1;
`else
  localparam bit WRITE_EN = 1'b0;
`endif

  localparam int PCW = $clog2(POLL_LIMIT + 1);
  localparam logic [PCW-1:0] POLL_MAX = PCW'(POLL_LIMIT);

  ctrl_state_t       state_reg, state_next;
  logic [15:0]       cmd_reg, cmd_next;
  logic              finish_reg, finish_next;
  logic              array_mode_reg, array_mode_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [DATA_W-1:0] wdata_reg, wdata_next;
  logic              ack_reg, ack_next;
  logic              err_reg, err_next;
  logic [DATA_W-1:0] rdata_reg, rdata_next;
  logic [15:0]       status_reg, status_next;
  logic [PCW-1:0]    poll_cnt_reg, poll_cnt_next, poll_inc;

  logic        bc_start, bc_rd, bc_done, bc_busy;
  logic [15:0] bc_wdata, bc_rd_data;

  flash_bus_cycle #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_bus (
    .clk       (clk),
    .rst       (rst),
    .start     (bc_start),
    .rd        (bc_rd),
    .wr_data   (bc_wdata),
    .done      (bc_done),
    .busy      (bc_busy),
    .ce        (flash_ce),
    .we        (flash_we),
    .oe        (flash_oe),
    .flash_data(flash_data),
    .rd_data   (bc_rd_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      cmd_reg        <= '0;
      finish_reg     <= 1'b0;
      array_mode_reg <= 1'b0;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      ack_reg        <= 1'b0;
      err_reg        <= 1'b0;
      rdata_reg      <= '0;
      status_reg     <= '0;
      poll_cnt_reg   <= '0;
    end else begin
      state_reg      <= state_next;
      cmd_reg        <= cmd_next;
      finish_reg     <= finish_next;
      array_mode_reg <= array_mode_next;
      addr_reg       <= addr_next;
      wdata_reg      <= wdata_next;
      ack_reg        <= ack_next;
      err_reg        <= err_next;
      rdata_reg      <= rdata_next;
      status_reg     <= status_next;
      poll_cnt_reg   <= poll_cnt_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    cmd_next        = cmd_reg;
    finish_next     = finish_reg;
    array_mode_next = array_mode_reg;
    addr_next       = addr_reg;
    wdata_next      = wdata_reg;
    ack_next        = 1'b0;
    err_next        = err_reg;
    rdata_next      = rdata_reg;
    status_next     = status_reg;
    poll_cnt_next   = poll_cnt_reg;
    poll_inc        = poll_cnt_reg + 1'b1;
    bc_start        = 1'b0;
    bc_rd           = 1'b1;
    bc_wdata        = cmd_reg;

    unique case (state_reg)
      ST_IDLE: begin
        if (req) begin
          addr_next   = addr;
          wdata_next  = wdata;
          finish_next = 1'b0;
          bc_start    = 1'b1;
          if (WRITE_EN && we) begin
            array_mode_next = 1'b0;
            cmd_next        = FLASH_CMD_PROGRAM;
            bc_rd           = 1'b0;
            bc_wdata        = FLASH_CMD_PROGRAM;
            state_next      = ST_CMD;
          end else if (array_mode_reg) begin
            state_next = ST_RD;
          end else begin
            cmd_next   = FLASH_CMD_READ_ARRAY;
            bc_rd      = 1'b0;
            bc_wdata   = FLASH_CMD_READ_ARRAY;
            state_next = ST_CMD;
          end
        end
      end

      ST_CMD: begin
        if (bc_done) begin
          if (cmd_reg == FLASH_CMD_PROGRAM) begin
            bc_start   = 1'b1;
            bc_rd      = 1'b0;
            bc_wdata   = wdata_reg;
            state_next = ST_PGM;
          end else begin
            array_mode_next = 1'b1;
            if (finish_reg) begin
              ack_next   = 1'b1;
              rdata_next = status_reg;
              state_next = ST_IDLE;
            end else begin
              bc_start   = 1'b1;
              state_next = ST_RD;
            end
          end
        end
      end

      ST_RD: begin
        if (bc_done) begin
          ack_next   = 1'b1;
          err_next   = 1'b0;
          rdata_next = swap_bytes(bc_rd_data, SWAP_BYTES != 0);
          state_next = ST_IDLE;
        end
      end

      ST_PGM: begin
        if (bc_done) begin
          bc_start      = 1'b1;
          poll_cnt_next = '0;
          state_next    = ST_POLL;
        end
      end

      ST_POLL: begin
        if (bc_done) begin
          status_next = bc_rd_data;
        end else if (!bc_busy) begin
          // Gap cycle between polls doubles as the decision point on the captured status.
          poll_cnt_next = poll_inc;
          bc_start      = 1'b1;
          if (status_reg[STATUS_READY_BIT] || poll_inc >= POLL_MAX) begin
            err_next    = !status_reg[STATUS_READY_BIT] ||
                          (|status_reg[STATUS_ERR_HI:STATUS_ERR_LO]);
            finish_next = 1'b1;
            cmd_next    = FLASH_CMD_READ_ARRAY;
            bc_rd       = 1'b0;
            bc_wdata    = FLASH_CMD_READ_ARRAY;
            state_next  = ST_CMD;
          end
        end
      end

      default: state_next = ST_IDLE;
    endcase
  end

  assign ready      = (state_reg == ST_IDLE);
  assign ack        = ack_reg;
  assign err        = err_reg;
  assign rdata      = rdata_reg;
  assign flash_addr = addr_reg;
  assign flash_rp   = 1'b1;
  assign flash_byte = 1'b1;
  assign flash_vpen = 1'b1;

endmodule

// File: tb/tb_flash_ctrl.sv
// Self-checking bench for flash_ctrl: table-driven reads plus reset, throughput and swap sequences.
// Program/poll sequences are exercised when FLASH_WRITE_EN is defined.
`timescale 1ns/1ps
module tb_flash_ctrl;

  localparam int AW = 23;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // DUT 0: default timing, POLL_LIMIT=8 for the timeout case
  logic          req0 = 1'b0, we0 = 1'b0;
  logic [AW-1:0] addr0 = '0;
  logic [15:0]   wdata0 = '0;
  logic          ready0, ack0, err0;
  logic [15:0]   rdata0;
  wire  [15:0]   fd0;
  logic [AW-1:0] fa0;
  logic          ce0, fwe0, oe0, rp0, byte0, vpen0;

  int            mode0 = 0;
  logic [15:0]   data0 = '0;
  int            pb0 = 0;
  int            polls0 = 0;
  logic          oe0_q = 1'b1;
  logic [15:0]   wlog0[$];
  logic [15:0]   model_val0;

  always_comb begin
    model_val0 = data0;
    if (mode0 == 1)      model_val0 = ((polls0 - pb0) > 3) ? 16'h0080 : 16'h0000;
    else if (mode0 == 2) model_val0 = 16'h0000;
  end
  assign fd0 = (!oe0 && !ce0) ? model_val0 : 16'hzzzz;

  always @(negedge clk) begin
    if (!fwe0 && !ce0) wlog0.push_back(fd0);
    if (!oe0 && oe0_q) polls0 = polls0 + 1;
    oe0_q = oe0;
  end

  flash_ctrl #(.ADDR_W(AW), .DATA_W(16), .WAIT_CYCLES(2), .SWAP_BYTES(0), .POLL_LIMIT(8)) u0 (
    .clk(clk), .rst(rst), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0),
    .ready(ready0), .ack(ack0), .err(err0), .rdata(rdata0),
    .flash_data(fd0), .flash_addr(fa0), .flash_ce(ce0), .flash_we(fwe0), .flash_oe(oe0),
    .flash_rp(rp0), .flash_byte(byte0), .flash_vpen(vpen0)
  );

  // DUT 1: byte-swapped read data
  logic          req1 = 1'b0, we1 = 1'b0;
  logic [AW-1:0] addr1 = '0;
  logic [15:0]   wdata1 = '0;
  logic          ready1, ack1, err1;
  logic [15:0]   rdata1;
  wire  [15:0]   fd1;
  logic [AW-1:0] fa1;
  logic          ce1, fwe1, oe1, rp1, byte1, vpen1;

  assign fd1 = (!oe1 && !ce1) ? 16'hA55A : 16'hzzzz;

  flash_ctrl #(.ADDR_W(AW), .DATA_W(16), .WAIT_CYCLES(2), .SWAP_BYTES(1), .POLL_LIMIT(4095)) u1 (
    .clk(clk), .rst(rst), .req(req1), .we(we1), .addr(addr1), .wdata(wdata1),
    .ready(ready1), .ack(ack1), .err(err1), .rdata(rdata1),
    .flash_data(fd1), .flash_addr(fa1), .flash_ce(ce1), .flash_we(fwe1), .flash_oe(oe1),
    .flash_rp(rp1), .flash_byte(byte1), .flash_vpen(vpen1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s = 0x%0h", name, act);
    end
  endtask

  // One request on DUT 0; lat is the cycle of ack counting the accept cycle as 0.
  task automatic op0(input logic w, input logic [AW-1:0] a, input logic [15:0] d,
                     output int lat, output logic [AW-1:0] seen_addr);
    int overlap;
    overlap   = 0;
    seen_addr = '0;
    @(posedge clk); #1;
    req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d;
    chk("ready_before_accept", 32'(ready0), 32'd1);
    @(posedge clk); #1;
    req0 = 1'b0;
    lat  = 1;
    while (!ack0 && lat < 200) begin
      if (!oe0) seen_addr = fa0;
      if (!oe0 && !fwe0) overlap++;
      @(posedge clk); #1;
      lat++;
    end
    chk("strobe_overlap_cycles", 32'(overlap), 32'd0);
    $display("op we=%0b addr=0x%06h -> lat=%0d rdata=0x%04h err=%0b", w, a, lat, rdata0, err0);
  endtask

  typedef struct {
    logic          w;
    logic [AW-1:0] a;
    logic [15:0]   model;
    logic [15:0]   exp_rdata;
    int            exp_lat;
    int            exp_writes;
  } vec_t;

  vec_t vecs[$];

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    int            lat;
    int            w0;
    int            cnt;
    int            acks;
    logic [AW-1:0] sa;

    vecs.push_back('{1'b0, 23'h000010, 16'h1234, 16'h1234, 7, 1});
    vecs.push_back('{1'b0, 23'h000011, 16'hABCD, 16'hABCD, 4, 0});
    vecs.push_back('{1'b0, 23'h7FFFFF, 16'hFFFF, 16'hFFFF, 4, 0});
    vecs.push_back('{1'b0, 23'h000000, 16'h0000, 16'h0000, 4, 0});
`ifndef FLASH_WRITE_EN
    vecs.push_back('{1'b1, 23'h000123, 16'h5555, 16'h5555, 4, 0});
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("rst_strobes_ce_we_oe", 32'({ce0, fwe0, oe0}), 32'h7);
    chk("rst_ready", 32'(ready0), 32'd1);
    chk("rst_ack", 32'(ack0), 32'd0);
    chk("rst_err", 32'(err0), 32'd0);
    chk("rst_rdata", 32'(rdata0), 32'd0);
    chk("rst_flash_addr", 32'(fa0), 32'd0);
    chk("tied_rp_byte_vpen", 32'({rp0, byte0, vpen0}), 32'h7);
    rst = 1'b0;

    foreach (vecs[i]) begin
      mode0 = 0;
      data0 = vecs[i].model;
      w0    = wlog0.size();
      op0(vecs[i].w, vecs[i].a, 16'hBEEF, lat, sa);
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      chk($sformatf("v%0d_rdata", i), 32'(rdata0), 32'(vecs[i].exp_rdata));
      chk($sformatf("v%0d_err", i), 32'(err0), 32'd0);
      chk($sformatf("v%0d_flash_addr", i), 32'(sa), 32'(vecs[i].a));
      chk($sformatf("v%0d_cmd_writes", i), 32'(wlog0.size() - w0), 32'(vecs[i].exp_writes));
      if (vecs[i].exp_writes > 0 && wlog0.size() > w0)
        chk($sformatf("v%0d_cmd_code", i), 32'(wlog0[w0]), 32'h00FF);
    end

    // back-to-back reads with req held high
    data0 = 16'h4242;
    @(posedge clk); #1;
    req0 = 1'b1; we0 = 1'b0; addr0 = 23'h000020;
    cnt = 0;
    while (!ack0 && cnt < 50) begin @(posedge clk); #1; cnt++; end
    cnt = 0;
    do begin @(posedge clk); #1; cnt++; end while (!ack0 && cnt < 50);
    req0 = 1'b0;
    chk("b2b_period", 32'(cnt), 32'd4);
    chk("b2b_rdata", 32'(rdata0), 32'h4242);

    // DUT 1 swap path
    @(posedge clk); #1;
    req1 = 1'b1; addr1 = 23'h000010;
    @(posedge clk); #1;
    req1 = 1'b0;
    cnt = 1;
    while (!ack1 && cnt < 50) begin @(posedge clk); #1; cnt++; end
    chk("swap_latency", 32'(cnt), 32'd7);
    chk("swap_rdata", 32'(rdata1), 32'h5AA5);

    // asynchronous reset while oe is low
    repeat (2) @(posedge clk);
    #1;
    data0 = 16'h7777;
    req0 = 1'b1; addr0 = 23'h000030; we0 = 1'b0;
    @(posedge clk); #1;
    req0 = 1'b0;
    @(posedge clk); #2;
    chk("midrst_oe_low_before", 32'(oe0), 32'd0);
    rst = 1'b1;
    #1;
    chk("midrst_strobes", 32'({ce0, fwe0, oe0}), 32'h7);
    chk("midrst_ready", 32'(ready0), 32'd1);
    chk("midrst_rdata", 32'(rdata0), 32'd0);
    chk("midrst_flash_addr", 32'(fa0), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    acks = 0;
    repeat (10) begin @(posedge clk); #1; if (ack0) acks++; end
    chk("midrst_no_ack", 32'(acks), 32'd0);
    data0 = 16'h3131;
    w0 = wlog0.size();
    op0(1'b0, 23'h000031, 16'h0000, lat, sa);
    chk("postrst_latency", 32'(lat), 32'd7);
    chk("postrst_rdata", 32'(rdata0), 32'h3131);
    chk("postrst_cmd_writes", 32'(wlog0.size() - w0), 32'd1);
    if (wlog0.size() > w0) chk("postrst_cmd_code", 32'(wlog0[w0]), 32'h00FF);

`ifdef FLASH_WRITE_EN
    // program, flash busy for three polls
    pb0 = polls0; mode0 = 1; w0 = wlog0.size();
    op0(1'b1, 23'h000100, 16'hBEEF, lat, sa);
    chk("pgm_latency", 32'(lat), 32'd26);
    chk("pgm_rdata", 32'(rdata0), 32'h0080);
    chk("pgm_err", 32'(err0), 32'd0);
    chk("pgm_polls", 32'(polls0 - pb0), 32'd4);
    chk("pgm_writes", 32'(wlog0.size() - w0), 32'd3);
    if (wlog0.size() >= w0 + 3) begin
      chk("pgm_w0_cmd", 32'(wlog0[w0]), 32'h0040);
      chk("pgm_w1_data", 32'(wlog0[w0+1]), 32'hBEEF);
      chk("pgm_w2_cmd", 32'(wlog0[w0+2]), 32'h00FF);
    end

    // program that never completes: timeout after POLL_LIMIT polls
    pb0 = polls0; mode0 = 2; w0 = wlog0.size();
    op0(1'b1, 23'h000101, 16'h1357, lat, sa);
    chk("tmo_latency", 32'(lat), 32'd42);
    chk("tmo_err", 32'(err0), 32'd1);
    chk("tmo_rdata", 32'(rdata0), 32'h0000);
    chk("tmo_polls", 32'(polls0 - pb0), 32'd8);
    chk("tmo_writes", 32'(wlog0.size() - w0), 32'd3);
    if (wlog0.size() >= w0 + 3) chk("tmo_w1_data", 32'(wlog0[w0+1]), 32'h1357);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
